// File: rtl/if_id_reg.sv
// IF/ID pipeline register: latches the fetched PC/instruction, flags fetch address faults,
// pre-decodes the extender mode and (with IF_ID_BD_EN defined) tracks branch delay slots.
module if_id_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [15:0] imm16_d,
  output logic [4:0]  extop_d,
  output logic [4:0]  exccode_d,
  output logic        bd_d,
  output logic        valid_d
);

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] PC_LO    = 32'h0000_3000;
  localparam logic [31:0] PC_HI    = 32'h0000_6FFC;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [4:0]  EXT_SIGN = 5'd0;
  localparam logic [4:0]  EXT_ZERO = 5'd1;
  localparam logic [4:0]  EXT_LUI  = 5'd2;

  logic [31:0] instr_reg, pc_reg;
  logic [4:0]  extop_reg, exccode_reg;
  logic        valid_reg;

  logic        fetch_fault;
  logic        is_branch;
  logic [4:0]  extop_next;
  logic [5:0]  opcode, funct;

  assign opcode      = instr_f[31:26];
  assign funct       = instr_f[5:0];
  assign fetch_fault = (pc_f[1:0] != 2'b00) || (pc_f < PC_LO) || (pc_f > PC_HI);

  always_comb begin
    is_branch = 1'b0;
    case (opcode)
      6'b000001, 6'b000010, 6'b000011, 6'b000100,
      6'b000101, 6'b000110, 6'b000111: is_branch = 1'b1;
      6'b000000: is_branch = (funct == 6'b001000) || (funct == 6'b001001);
      default:   is_branch = 1'b0;
    endcase
  end

  // A faulting fetch latches a nop, so its extender mode is that of the nop.
  always_comb begin
    extop_next = EXT_SIGN;
    if (!fetch_fault) begin
      case (opcode)
        6'b001100, 6'b001101, 6'b001110: extop_next = EXT_ZERO;
        6'b001111:                       extop_next = EXT_LUI;
        default:                         extop_next = EXT_SIGN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_reg   <= 32'h0;
      pc_reg      <= PC_RESET;
      extop_reg   <= EXT_SIGN;
      exccode_reg <= 5'd0;
      valid_reg   <= 1'b0;
    end else if (flush) begin
      instr_reg   <= 32'h0;
      pc_reg      <= pc_f;
      extop_reg   <= EXT_SIGN;
      exccode_reg <= 5'd0;
      valid_reg   <= 1'b0;
    end else if (!stall) begin
      instr_reg   <= fetch_fault ? 32'h0 : instr_f;
      pc_reg      <= pc_f;
      extop_reg   <= extop_next;
      exccode_reg <= fetch_fault ? EXC_ADEL : 5'd0;
      valid_reg   <= 1'b1;
    end
  end

`ifdef IF_ID_BD_EN
  logic last_br_reg, bd_reg;

  // bd takes the previous capture's branch flag, faulting fetches included, for EPC correction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_br_reg <= 1'b0;
      bd_reg      <= 1'b0;
    end else if (flush) begin
      last_br_reg <= 1'b0;
      bd_reg      <= 1'b0;
    end else if (!stall) begin
      last_br_reg <= is_branch && !fetch_fault;
      bd_reg      <= last_br_reg;
    end
  end

  assign bd_d = bd_reg;
`else
  assign bd_d = 1'b0;
`endif

  assign instr_d   = instr_reg;
  assign pc_d      = pc_reg;
  assign imm16_d   = instr_reg[15:0];
  assign extop_d   = extop_reg;
  assign exccode_d = exccode_reg;
  assign valid_d   = valid_reg;

endmodule

// File: tb/tb_if_id_reg.sv
// Directed bench for if_id_reg: a reference model pushes expected D-stage values per cycle
// into a queue, and each is popped and compared one edge later.
module tb_if_id_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] pc_f, instr_f;
  logic [31:0] instr_d, pc_d;
  logic [15:0] imm16_d;
  logic [4:0]  extop_d, exccode_d;
  logic        bd_d, valid_d;

  if_id_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .pc_f(pc_f), .instr_f(instr_f),
    .instr_d(instr_d), .pc_d(pc_d), .imm16_d(imm16_d), .extop_d(extop_d),
    .exccode_d(exccode_d), .bd_d(bd_d), .valid_d(valid_d)
  );

  always #5 clk = ~clk;

`ifdef IF_ID_BD_EN
  localparam bit BD_EN = 1'b1;
`else
  localparam bit BD_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  extop;
    logic [4:0]  exc;
    logic        bd;
    logic        valid;
  } exp_t;

  exp_t q[$];
  exp_t held;
  bit   m_last_br;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t reset_vals();
    exp_t e;
    e.instr = 32'h0; e.pc = 32'h3000; e.extop = 5'd0;
    e.exc = 5'd0; e.bd = 1'b0; e.valid = 1'b0;
    return e;
  endfunction

  // Drive one cycle of stimulus, predict the registered result, compare after the edge.
  task automatic cycle(input bit st, input bit fl, input logic [31:0] pc, input logic [31:0] ins);
    exp_t e, got;
    bit   bad_addr, br;
    logic [5:0] op, fn;
    @(negedge clk);
    stall = st; flush = fl; pc_f = pc; instr_f = ins;
    op = ins[31:26];
    fn = ins[5:0];
    bad_addr = !((pc[1:0] == 2'b00) && (pc >= 32'h3000) && (pc <= 32'h6FFC));
    br = (op inside {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7}) ||
         (op == 6'd0 && (fn == 6'd8 || fn == 6'd9));
    e = held;
    if (fl) begin
      e.instr = 32'h0; e.pc = pc; e.extop = 5'd0; e.exc = 5'd0; e.bd = 1'b0; e.valid = 1'b0;
      m_last_br = 1'b0;
    end else if (!st) begin
      e.pc    = pc;
      e.valid = 1'b1;
      e.bd    = BD_EN && m_last_br;
      if (bad_addr) begin
        e.instr = 32'h0; e.extop = 5'd0; e.exc = 5'd4;
      end else begin
        e.instr = ins; e.exc = 5'd0;
        e.extop = (op == 6'b001111) ? 5'd2 :
                  (op inside {6'b001100, 6'b001101, 6'b001110}) ? 5'd1 : 5'd0;
      end
      m_last_br = BD_EN && br && !bad_addr;
    end
    q.push_back(e);
    held = e;
    @(posedge clk);
    #1;
    got = q.pop_front();
    $display("txn stall=%0b flush=%0b pc_f=%h instr_f=%h -> instr_d=%h pc_d=%h ext=%0d exc=%0d bd=%0b v=%0b",
             st, fl, pc, ins, instr_d, pc_d, extop_d, exccode_d, bd_d, valid_d);
    chk("instr_d", instr_d, got.instr);
    chk("pc_d", pc_d, got.pc);
    chk("imm16_d", {16'h0, imm16_d}, {16'h0, got.instr[15:0]});
    chk("extop_d", {27'h0, extop_d}, {27'h0, got.extop});
    chk("exccode_d", {27'h0, exccode_d}, {27'h0, got.exc});
    chk("bd_d", {31'h0, bd_d}, {31'h0, got.bd});
    chk("valid_d", {31'h0, valid_d}, {31'h0, got.valid});
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_instr"}, instr_d, 32'h0);
    chk({tag, "_pc"}, pc_d, 32'h3000);
    chk({tag, "_imm"}, {16'h0, imm16_d}, 32'h0);
    chk({tag, "_ext"}, {27'h0, extop_d}, 32'h0);
    chk({tag, "_exc"}, {27'h0, exccode_d}, 32'h0);
    chk({tag, "_bd"}, {31'h0, bd_d}, 32'h0);
    chk({tag, "_valid"}, {31'h0, valid_d}, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_reset_state("reset_async");
    @(negedge clk);
    reset = 1'b1;
    held = reset_vals();
    m_last_br = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; pc_f = 32'h3000; instr_f = 32'h0;
    // Load some non-reset state first, then assert reset mid-cycle, away from an edge.
    held = reset_vals();
    m_last_br = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cycle(0, 0, 32'h3010, 32'h3421_00FF);
    #2;
    do_reset();

    // lui just after release
    cycle(0, 0, 32'h3000, 32'h3C01_1234);
    chk("lui_ext", {27'h0, extop_d}, 32'd2);
    chk("lui_imm", {16'h0, imm16_d}, 32'h1234);

    // fetch faults: misaligned, above range, below range
    cycle(0, 0, 32'h3002, 32'h3421_00FF);
    chk("fault_misalign_exc", {27'h0, exccode_d}, 32'd4);
    cycle(0, 0, 32'h7000, 32'h3421_00FF);
    chk("fault_high_exc", {27'h0, exccode_d}, 32'd4);
    cycle(0, 0, 32'h2FFC, 32'h0000_0000);
    cycle(0, 0, 32'h6FFC, 32'h2001_0005);

    // delay slot: beq, ori, then a plain instruction
    cycle(0, 0, 32'h3000, 32'h1000_0003);
    cycle(0, 0, 32'h3004, 32'h3421_00FF);
    chk("ds_bd", {31'h0, bd_d}, {31'h0, BD_EN});
    chk("ds_ext", {27'h0, extop_d}, 32'd1);
    cycle(0, 0, 32'h3008, 32'h0000_0000);
    chk("ds_after_bd", {31'h0, bd_d}, 32'h0);

    // stall three cycles holding a delay-slot instruction
    cycle(0, 0, 32'h300C, 32'h0800_0C00);
    cycle(0, 0, 32'h3010, 32'h3C02_ABCD);
    for (int i = 0; i < 3; i++) cycle(1, 0, 32'h3014 + 32'(4 * i), 32'h3803_0001);
    chk("stall_hold_pc", pc_d, 32'h3010);
    // stall released: pending branch flag from the jump is consumed already
    cycle(0, 0, 32'h3014, 32'h3803_0001);

    // flush overrides stall, and clears the branch flag
    cycle(0, 0, 32'h3018, 32'h0800_0C00);
    cycle(1, 1, 32'h301C, 32'h3421_00FF);
    chk("flush_valid", {31'h0, valid_d}, 32'h0);
    cycle(0, 0, 32'h3020, 32'h3421_00FF);
    chk("flush_clears_br", {31'h0, bd_d}, 32'h0);

    // jr then a faulting fetch in its delay slot
    cycle(0, 0, 32'h3024, 32'h03E0_0008);
    cycle(0, 0, 32'h3006, 32'h3421_00FF);
    chk("dsfault_exc", {27'h0, exccode_d}, 32'd4);
    chk("dsfault_bd", {31'h0, bd_d}, {31'h0, BD_EN});
    // a faulting branch word does not mark the next slot
    cycle(0, 0, 32'h7004, 32'h1000_0003);
    cycle(0, 0, 32'h3028, 32'h0000_0000);
    cycle(0, 0, 32'h302C, 32'h0000_0009 | 32'h03E0_0000);
    cycle(0, 0, 32'h3030, 32'h3521_0001);

    // reset asserted during stall+flush dominates both
    @(negedge clk);
    stall = 1'b1; flush = 1'b1;
    #2;
    do_reset();
    cycle(0, 0, 32'h3034, 32'h3C05_0F0F);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain observed %0d expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-low; 0 clears all state immediately, independent of clk.
REQ-003 SHALL have port stall, input, 1: 1 = hold all D-stage outputs and internal state.
REQ-004 SHALL have port flush, input, 1: 1 = load a bubble (exception entry, eret).
REQ-005 SHALL have port pc_f, input, 32: PC of the instruction being fetched.
REQ-006 SHALL have port instr_f, input, 32: instruction word from IM for pc_f.
REQ-007 SHALL have port instr_d, output, 32: latched instruction; 0x0000_0000 (nop) for a bubble or faulting fetch.
REQ-008 SHALL have port pc_d, output, 32: latched PC.
REQ-009 SHALL have port imm16_d, output, 16: instr_d[15:0], the immediate input of the D-stage extender.
REQ-010 SHALL have port extop_d, output, 5: extender mode; 0 sign-extend, 1 zero-extend, 2 load-upper.
REQ-011 SHALL have port exccode_d, output, 5: 0 none, 4 AdEL on fetch.
REQ-012 SHALL have port bd_d, output, 1: instr_d sits in a branch delay slot.
REQ-013 SHALL have port valid_d, output, 1: 1 = instr_d came from a real fetch, not a bubble.

Function
REQ-014 On each rising edge with stall=0 and flush=0, the block SHALL register pc_f, a fetch check and instr_f; outputs are valid one cycle after capture.
REQ-015 A fetch SHALL fault when pc_f[1:0]!=0 or pc_f is outside 0x0000_3000..0x0000_6FFC; the block then SHALL latch exccode_d=4, instr_d=0, valid_d=1 and pc_d=pc_f.
REQ-016 With stall=1 and flush=0, every output and internal register SHALL hold its value.
REQ-017 With flush=1, the block SHALL latch a bubble: instr_d=0, exccode_d=0, bd_d=0, valid_d=0 and pc_d=pc_f; flush SHALL override stall in the same cycle.
REQ-018 extop_d SHALL be decoded from the captured instruction: opcode 001100/001101/001110 -> 1; opcode 001111 -> 2; anything else -> 0.
REQ-019 extop_d SHALL be registered, not combinational from instr_d.
REQ-020 A branch/jump SHALL be any of:
- opcodes 000001, 000010, 000011, 000100, 000101, 000110, 000111;
- opcode 000000 with funct 001000 or 001001.
REQ-021 An internal last_br flag SHALL update on every non-stalled capture to "captured instruction is a branch/jump and not faulting"; bd_d SHALL be loaded from the previous last_br value.
REQ-022 flush SHALL clear last_br.
REQ-023 A faulting fetch SHALL still carry bd_d from last_br, so EPC correction works in the delay slot.

Reset
REQ-024 While reset=0, the block SHALL drive:
- instr_d=0, pc_d=0x0000_3000, imm16_d=0, extop_d=0;
- exccode_d=0, bd_d=0, valid_d=0;
- last_br=0.
REQ-025 Reset mid-stall or mid-flush SHALL take priority over both; the first capture after release SHALL obey REQ-014..REQ-017.

Configuration
REQ-026 Macro IF_ID_BD_EN SHALL control delay-slot tracking.
- Defined: REQ-021..REQ-023 apply.
- Undefined: last_br is not implemented and bd_d is tied to 0.

Verification
REQ-027 Reset: assert reset=0 mid-cycle -> outputs take the REQ-024 values immediately; release, then pc_f=0x3000, instr_f=0x3C01_1234 -> next edge gives extop_d=2, imm16_d=0x1234, valid_d=1.
REQ-028 Fetch fault: pc_f=0x3002 -> exccode_d=4, instr_d=0, pc_d=0x3002; pc_f=0x7000 -> exccode_d=4.
REQ-029 Delay slot (IF_ID_BD_EN defined): beq 0x1000_0003 @0x3000, then ori 0x3421_00FF @0x3004 -> second capture bd_d=1, extop_d=1; third capture bd_d=0.
REQ-030 Stall/flush: stall=1 for 3 cycles -> outputs unchanged; stall=1 with flush=1 -> bubble (valid_d=0, instr_d=0, bd_d=0).
REQ-031 Delay-slot fault: jr 0x03E0_0008 followed by fetch at 0x3006 -> exccode_d=4, bd_d=1.
REQ-032 Macro off: build without IF_ID_BD_EN and rerun the REQ-029 sequence -> bd_d=0 throughout.
